game_sequencer: RTL

Top-level game-flow controller for the Space Invaders design. It sequences the player ship, the enemy wave and the score display through five phases: attract, play, life-lost pause, level-clear banner and game over. It issues the new-game, wave-reset and bonus-life strobes that the player and enemy blocks consume, and it holds the level and score registers. It sits between the button conditioners and the player and enemy blocks, and is clocked by the pixel clock with a one-cycle-per-frame `frame_i` strobe.

---
 rtl/game_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
// Game-flow controller: sequences attract (IDLE), PLAY, LIFE_LOST pause,
// LEVEL_CLEAR banner and GAME_OVER. It issues the new-game, wave-reset and
// bonus-life strobes and holds the level and score registers.
//
// Build option:
//   GAME_SEQ_BONUS_LIFE_EN  defined   -> add_life_o requests a life after each
//                                        even level is cleared
//                           undefined -> add_life_o tied low, logic not built
//
// Ports:
//   clk_i              pixel clock
//   reset_i            asynchronous, active-high reset
//   frame_i            one-cycle strobe at the start of each video frame
//   start_i            debounced start button (level)
//   player_alive_i     low when no lives remain
//   player_hit_i       player struck by an enemy bullet
//   enemy_killed_i     one cycle per enemy destroyed
//   wave_clear_i       no enemies remain
//   invaders_landed_i  enemy wave reached the player row
//   state_o[4:0]       one-hot phase
//   freeze_o           halts player/enemy motion (every phase except PLAY)
//   new_game_o         one-cycle strobe on entry to PLAY from IDLE/GAME_OVER
//   wave_reset_o       one-cycle strobe on entry to PLAY from LEVEL_CLEAR or
//                      together with new_game_o
//   add_life_o         bonus-life level request
//   level_o[3:0]       current level, 1..max_level_p
//   score_o[15:0]      binary score, saturating
// -----------------------------------------------------------------------------
module game_sequencer #(
   parameter int unsigned clear_frames_p = 120,
   parameter int unsigned max_level_p    = 9,
   parameter int unsigned points_p       = 10
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        frame_i,
   input  logic        start_i,
   input  logic        player_alive_i,
   input  logic        player_hit_i,
   input  logic        enemy_killed_i,
   input  logic        wave_clear_i,
   input  logic        invaders_landed_i,
   output logic [4:0]  state_o,
   output logic        freeze_o,
   output logic        new_game_o,
   output logic        wave_reset_o,
   output logic        add_life_o,
   output logic [3:0]  level_o,
   output logic [15:0] score_o
);

   localparam int unsigned cnt_w_lp = (clear_frames_p > 1) ? $clog2(clear_frames_p) : 1;

   localparam logic [cnt_w_lp-1:0] cnt_load_lp = cnt_w_lp'(clear_frames_p - 1);
   localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);
   localparam logic [3:0]          max_level_lp = 4'(max_level_p);
   localparam logic [16:0]         points_lp    = 17'(points_p);

   localparam logic [4:0] st_idle_lp  = 5'b00001;
   localparam logic [4:0] st_play_lp  = 5'b00010;
   localparam logic [4:0] st_lost_lp  = 5'b00100;
   localparam logic [4:0] st_clear_lp = 5'b01000;
   localparam logic [4:0] st_over_lp  = 5'b10000;

   logic [4:0]          state_q, state_d;
   logic                start_q;
   logic                start_evt;
   logic [cnt_w_lp-1:0] cnt_q, cnt_d;
   logic [3:0]          level_q, level_d;
   logic [15:0]         score_q, score_d;
   logic [16:0]         score_sum;
   logic                new_game_q, new_game_d;
   logic                wave_reset_q, wave_reset_d;

   // Rising edge of the start button; start_q resets high so a button held
   // through reset does not start a game.
   assign start_evt = start_i & ~start_q;

   // State and datapath registers
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= st_idle_lp;
         start_q      <= 1'b1;
         cnt_q        <= '0;
         level_q      <= 4'd1;
         score_q      <= 16'd0;
         new_game_q   <= 1'b0;
         wave_reset_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_i;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         score_q      <= score_d;
         new_game_q   <= new_game_d;
         wave_reset_q <= wave_reset_d;
      end
   end

   // Next-state logic; PLAY exits are checked in priority order
   always_comb begin
      state_d = state_q;
      case (state_q)
         st_idle_lp: begin
            if (start_evt) state_d = st_play_lp;
         end
         st_play_lp: begin
            if (invaders_landed_i | ~player_alive_i) state_d = st_over_lp;
            else if (player_hit_i)                    state_d = st_lost_lp;
            else if (wave_clear_i)                    state_d = st_clear_lp;
         end
         st_lost_lp: begin
            if (start_evt) state_d = st_play_lp;
         end
         st_clear_lp: begin
            if (frame_i && (cnt_q == '0)) state_d = st_play_lp;
         end
         st_over_lp: begin
            if (start_evt) state_d = st_play_lp;
         end
         default: state_d = st_idle_lp;
      endcase
   end

   // Output and datapath next-values
   always_comb begin
      freeze_o     = (state_q != st_play_lp);
      new_game_d   = 1'b0;
      wave_reset_d = 1'b0;
      level_d      = level_q;
      score_d      = score_q;
      cnt_d        = cnt_q;
      score_sum    = {1'b0, score_q} + points_lp;
      case (state_q)
         st_idle_lp, st_over_lp: begin
            if (start_evt) begin
               new_game_d   = 1'b1;
               wave_reset_d = 1'b1;
               level_d      = 4'd1;
               score_d      = 16'd0;
            end
         end
         st_play_lp: begin
            // A kill is counted even in the cycle PLAY is left.
            if (enemy_killed_i) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (state_d == st_clear_lp) cnt_d = cnt_load_lp;
         end
         st_clear_lp: begin
            if (frame_i) begin
               if (cnt_q == '0) begin
                  wave_reset_d = 1'b1;
                  level_d      = (level_q >= max_level_lp) ? max_level_lp : level_q + 4'd1;
               end else begin
                  cnt_d = cnt_q - cnt_one_lp;
               end
            end
         end
         default: ;
      endcase
   end

`ifdef GAME_SEQ_BONUS_LIFE_EN
   logic add_life_q, add_life_d;

   // Raised on entry to the banner after an even level; held until the player
   // has seen it with a frame strobe, so exactly one life is granted.
   always_comb begin
      add_life_d = 1'b0;
      if ((state_q == st_play_lp) && (state_d == st_clear_lp)) add_life_d = ~level_q[0];
      else if (state_q == st_clear_lp)                          add_life_d = add_life_q & ~frame_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) add_life_q <= 1'b0;
      else         add_life_q <= add_life_d;
   end

   assign add_life_o = add_life_q;
`else
   assign add_life_o = 1'b0;
`endif

   assign state_o      = state_q;
   assign new_game_o   = new_game_q;
   assign wave_reset_o = wave_reset_q;
   assign level_o      = level_q;
   assign score_o      = score_q;

endmodule
